// File: rtl/segment_descriptor_pkg.sv
// Shared 386 segment descriptor definitions.
// Bit positions, image layout and writer FSM states.
package segment_descriptor_pkg;

  localparam int BASE_MID_POS = 0;
  localparam int TYPE_POS     = 8;
  localparam int ACCESSED_BIT = 8;
  localparam int S_BIT        = 12;
  localparam int DPL_POS      = 13;
  localparam int P_BIT        = 15;
  localparam int LIMIT_HI_POS = 16;
  localparam int AVL_BIT      = 20;
  localparam int D_BIT        = 22;
  localparam int G_BIT        = 23;
  localparam int BASE_HI_POS  = 24;
  localparam int LIMIT_LO_POS = 32;
  localparam int BASE_LO_POS  = 48;

  localparam logic [3:0] BE_ALL   = 4'b1111;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_LO,
    WRITE_HI,
    WRITE_ACC
  } wr_state_e;

  typedef struct packed {
    logic [15:0] base_15_0;
    logic [15:0] limit_15_0;
    logic [7:0]  base_31_24;
    logic        g;
    logic        d;
    logic        rsvd;
    logic        avl;
    logic [3:0]  limit_19_16;
    logic        p;
    logic [1:0]  dpl;
    logic        s;
    logic [3:0]  seg_type;
    logic [7:0]  base_23_16;
  } segment_descriptor_t;

endpackage

// File: rtl/segment_descriptor_writer_if.sv
// Request and memory-bus signals of the descriptor writer.
// slave = writer side, master = requester/bus side.
interface segment_descriptor_writer_if #(
  parameter int TABLE_INDEX_WIDTH = 13
);
  logic                         i_request_valid;
  logic                         o_request_ready;
  logic                         i_accessed_only;
  logic [31:0]                  i_table_base;
  logic [TABLE_INDEX_WIDTH-1:0] i_table_index;
  logic [31:0]                  i_base;
  logic [19:0]                  i_limit;
  logic                         i_present;
  logic                         i_granularity;
  logic                         i_default_operation_size;
  logic                         i_available_field;
  logic                         i_segment_type;
  logic [1:0]                   i_privilege_level;
  logic [3:0]                   i_type;
  logic                         o_bus_request;
  logic [31:0]                  o_bus_address;
  logic [31:0]                  o_bus_data;
  logic [3:0]                   o_bus_byte_enable;
  logic                         i_bus_ready;
  logic                         o_done;
  logic [63:0]                  o_descriptor;

  modport slave (
    input  i_request_valid, i_accessed_only,
    input  i_table_base, i_table_index,
    input  i_base, i_limit, i_present,
    input  i_granularity,
    input  i_default_operation_size,
    input  i_available_field, i_segment_type,
    input  i_privilege_level, i_type,
    input  i_bus_ready,
    output o_request_ready, o_bus_request,
    output o_bus_address, o_bus_data,
    output o_bus_byte_enable, o_done,
    output o_descriptor
  );

  modport master (
    output i_request_valid, i_accessed_only,
    output i_table_base, i_table_index,
    output i_base, i_limit, i_present,
    output i_granularity,
    output i_default_operation_size,
    output i_available_field, i_segment_type,
    output i_privilege_level, i_type,
    output i_bus_ready,
    input  o_request_ready, o_bus_request,
    input  o_bus_address, o_bus_data,
    input  o_bus_byte_enable, o_done,
    input  o_descriptor
  );
endinterface

// File: rtl/segment_descriptor_encode.sv
// Combinational packer: decoded fields to 64-bit image.
// Bit 21 is reserved and always written as zero.
module segment_descriptor_encode
  import segment_descriptor_pkg::*;
(
  input  logic [31:0]         base_i,
  input  logic [19:0]         limit_i,
  input  logic                p_i,
  input  logic                g_i,
  input  logic                d_i,
  input  logic                avl_i,
  input  logic                s_i,
  input  logic [1:0]          dpl_i,
  input  logic [3:0]          type_i,
  output segment_descriptor_t desc_o
);

  logic [63:0] img;

  // Scatter each field into its fixed descriptor position.
  always_comb begin
    img = '0;
    img[BASE_LO_POS +: 16]  = base_i[15:0];
    img[BASE_MID_POS +: 8]  = base_i[23:16];
    img[BASE_HI_POS +: 8]   = base_i[31:24];
    img[LIMIT_LO_POS +: 16] = limit_i[15:0];
    img[LIMIT_HI_POS +: 4]  = limit_i[19:16];
    img[G_BIT]              = g_i;
    img[D_BIT]              = d_i;
    img[AVL_BIT]            = avl_i;
    img[P_BIT]              = p_i;
    img[DPL_POS +: 2]       = dpl_i;
    img[S_BIT]              = s_i;
    img[TYPE_POS +: 4]      = type_i;
  end

  assign desc_o = img;

endmodule

// File: rtl/segment_descriptor_writer.sv
// Writes a packed descriptor into a GDT/LDT entry
// as two dword writes, or sets its accessed bit alone.
module segment_descriptor_writer
  import segment_descriptor_pkg::*;
#(
  parameter int TABLE_INDEX_WIDTH = 13
) (
  input logic                        i_clk,
  input logic                        i_reset_n,
  segment_descriptor_writer_if.slave bus
);

  wr_state_e           state_q, state_d;
  segment_descriptor_t desc_q, desc_d;
  segment_descriptor_t enc;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          be_q, be_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                rdy_q, rdy_d;
  logic [TABLE_INDEX_WIDTH-1:0] idx;
  logic [31:0]         entry;
  logic [31:0]         acc_word;

  segment_descriptor_encode u_enc (
    .base_i  (bus.i_base),
    .limit_i (bus.i_limit),
    .p_i     (bus.i_present),
    .g_i     (bus.i_granularity),
    .d_i     (bus.i_default_operation_size),
    .avl_i   (bus.i_available_field),
    .s_i     (bus.i_segment_type),
    .dpl_i   (bus.i_privilege_level),
    .type_i  (bus.i_type),
    .desc_o  (enc)
  );

  assign idx      = bus.i_table_index;
  assign entry    = bus.i_table_base
                  + 32'({idx, 3'b000});
  assign acc_word = enc[31:0]
                  | (32'd1 << ACCESSED_BIT);

  // Next state and next registered bus outputs.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_request_valid) begin
          desc_d = enc;
          addr_d = entry;
          req_d  = 1'b1;
          if (bus.i_accessed_only) begin
            state_d = WRITE_ACC;
            data_d  = acc_word;
            be_d    = BE_BYTE1;
          end else begin
            state_d = WRITE_LO;
            data_d  = enc[31:0];
            be_d    = BE_ALL;
          end
        end
      end
      WRITE_LO: begin
        if (bus.i_bus_ready) begin
          state_d = WRITE_HI;
          addr_d  = addr_q + 32'd4;
          data_d  = desc_q[63:32];
          be_d    = BE_ALL;
        end
      end
      WRITE_HI, WRITE_ACC: begin
        if (bus.i_bus_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons a write.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      desc_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      req_q   <= req_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.o_request_ready   = rdy_q;
  assign bus.o_bus_request     = req_q;
  assign bus.o_bus_address     = addr_q;
  assign bus.o_bus_data        = data_q;
  assign bus.o_bus_byte_enable = be_q;
  assign bus.o_done            = done_q;
  assign bus.o_descriptor      = desc_q;

endmodule

// File: tb/tb_segment_descriptor_writer.sv
// Bench for segment_descriptor_writer: directed cases
// plus random requests against a field-level model.
module tb_segment_descriptor_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  segment_descriptor_writer_if #(
    .TABLE_INDEX_WIDTH(13)
  ) bif ();

  segment_descriptor_writer #(
    .TABLE_INDEX_WIDTH(13)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          acc;
    logic [31:0] tbase;
    logic [12:0] idx;
    logic [31:0] base;
    logic [19:0] lim;
    bit          g, d, avl, p, s;
    logic [1:0]  dpl;
    logic [3:0]  typ;
  } req_t;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_desc(req_t r);
    logic [63:0] b, l, v;
    b = 64'(r.base);
    l = 64'(r.lim);
    v = ((b & 64'hFFFF) << 48)
      | ((l & 64'hFFFF) << 32)
      | ((b >> 24) << 24)
      | (64'(r.g) << 23)
      | (64'(r.d) << 22)
      | (64'(r.avl) << 20)
      | ((l >> 16) << 16)
      | (64'(r.p) << 15)
      | (64'(r.dpl) << 13)
      | (64'(r.s) << 12)
      | (64'(r.typ) << 8)
      | ((b >> 16) & 64'hFF);
    return v;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.acc   = 1'($urandom);
    r.tbase = $urandom;
    r.idx   = 13'($urandom);
    r.base  = $urandom;
    r.lim   = 20'($urandom);
    r.g     = 1'($urandom);
    r.d     = 1'($urandom);
    r.avl   = 1'($urandom);
    r.p     = 1'($urandom);
    r.s     = 1'($urandom);
    r.dpl   = 2'($urandom);
    r.typ   = 4'($urandom);
    return r;
  endfunction

  task automatic drive(input req_t r, input bit v);
    bif.i_request_valid          = v;
    bif.i_accessed_only          = r.acc;
    bif.i_table_base             = r.tbase;
    bif.i_table_index            = r.idx;
    bif.i_base                   = r.base;
    bif.i_limit                  = r.lim;
    bif.i_present                = r.p;
    bif.i_granularity            = r.g;
    bif.i_default_operation_size = r.d;
    bif.i_available_field        = r.avl;
    bif.i_segment_type           = r.s;
    bif.i_privilege_level        = r.dpl;
    bif.i_type                   = r.typ;
  endtask

  task automatic do_req(input req_t r,
                        input int wpct,
                        input int lo_waits);
    logic [63:0] ed;
    logic [31:0] a;
    logic [31:0] ea [2];
    logic [31:0] edat [2];
    logic [3:0]  ebe [2];
    int n, w, waits, cyc;
    bit rdy;
    ed = model_desc(r);
    a  = r.tbase + (32'(r.idx) * 32'd8);
    if (r.acc) begin
      n = 1;
      ea[0] = a;
      edat[0] = ed[31:0] | 32'h100;
      ebe[0] = 4'b0010;
    end else begin
      n = 2;
      ea[0] = a;
      edat[0] = ed[31:0];
      ebe[0] = 4'b1111;
      ea[1] = a + 32'd4;
      edat[1] = ed[63:32];
      ebe[1] = 4'b1111;
    end
    drive(r, 1'b1);
    bif.i_bus_ready = 1'($urandom);
    check("offer_ready", 64'(bif.o_request_ready), 1);
    @(posedge clk); #1;
    drive(rand_req(), 1'b0);
    cyc = 1;
    w = 0;
    waits = 0;
    while (w < n && cyc < 64) begin
      check("bus_req", 64'(bif.o_bus_request), 1);
      check("addr", 64'(bif.o_bus_address), 64'(ea[w]));
      check("data", 64'(bif.o_bus_data), 64'(edat[w]));
      check("be", 64'(bif.o_bus_byte_enable), 64'(ebe[w]));
      check("busy_done", 64'(bif.o_done), 0);
      check("busy_ready", 64'(bif.o_request_ready), 0);
      check("desc", bif.o_descriptor, ed);
      if (w == 0 && waits < lo_waits)
        rdy = 1'b0;
      else
        rdy = ($urandom_range(99) >= wpct);
      bif.i_bus_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) w++;
      else waits++;
    end
    if (w < n) check("timeout", 64'(w), 64'(n));
    check("done", 64'(bif.o_done), 1);
    check("done_ready", 64'(bif.o_request_ready), 1);
    check("done_bus_req", 64'(bif.o_bus_request), 0);
    check("done_desc", bif.o_descriptor, ed);
    if (lo_waits > 0 && wpct == 0)
      check("wait_lat", 64'(cyc), 64'(n + 1 + lo_waits));
    bif.i_bus_ready = 1'($urandom);
  endtask

  initial begin
    req_t r;
    logic [31:0] a;
    int k;
    drive(rand_req(), 1'b0);
    bif.i_bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bif.o_request_ready), 1);
    check("rst_bus_req", 64'(bif.o_bus_request), 0);
    check("rst_addr", 64'(bif.o_bus_address), 0);
    check("rst_data", 64'(bif.o_bus_data), 0);
    check("rst_be", 64'(bif.o_bus_byte_enable), 0);
    check("rst_done", 64'(bif.o_done), 0);
    check("rst_desc", bif.o_descriptor, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    r = '{acc:0, tbase:32'h0001_0000, idx:13'd2,
          base:32'h1234_5678, lim:20'hABCDE,
          g:1, d:1, avl:0, p:1, s:1,
          dpl:2'd3, typ:4'hA};
    do_req(r, 0, 0);
    check("spec_desc", bif.o_descriptor,
          64'h5678_BCDE_12CA_FA34);

    do_req(r, 0, 3);

    r = '{acc:1, tbase:32'h0000_2000, idx:13'd5,
          base:32'h0, lim:20'h0,
          g:0, d:0, avl:0, p:0, s:0,
          dpl:2'd0, typ:4'h0};
    do_req(r, 0, 0);

    r = rand_req();
    r.acc = 1'b0;
    r.tbase = 32'hFFFF_FFF8;
    r.idx = 13'd1;
    do_req(r, 0, 0);

    r = rand_req();
    r.acc = 1'b0;
    do_req(r, 0, 0);
    r = rand_req();
    r.acc = 1'b0;
    do_req(r, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_req(rand_req(), 30, 0);
      k = $urandom_range(2);
      for (int j = 0; j < k; j++) begin
        @(posedge clk); #1;
        check("idle_done", 64'(bif.o_done), 0);
        check("idle_bus_req", 64'(bif.o_bus_request), 0);
      end
    end

    r = rand_req();
    r.acc = 1'b0;
    a = r.tbase + (32'(r.idx) * 32'd8);
    drive(r, 1'b1);
    bif.i_bus_ready = 1'b1;
    @(posedge clk); #1;
    drive(rand_req(), 1'b0);
    @(posedge clk); #1;
    bif.i_bus_ready = 1'b0;
    check("hi_bus_req", 64'(bif.o_bus_request), 1);
    check("hi_addr", 64'(bif.o_bus_address), 64'(a + 32'd4));
    rst_n = 1'b0;
    #1;
    check("arst_bus_req", 64'(bif.o_bus_request), 0);
    check("arst_done", 64'(bif.o_done), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    bif.i_bus_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check("post_ready", 64'(bif.o_request_ready), 1);
      check("post_done", 64'(bif.o_done), 0);
      check("post_bus_req", 64'(bif.o_bus_request), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
